// File: rtl/reg4_bank_ctrl_if.sv
// Requester/bank-side signal bundle for reg4_bank_ctrl.
// Optional err_a/err_b ports exist only when REG4_BANK_CTRL_ERR_EN is defined.
interface reg4_bank_ctrl_if #(
    parameter int NREG = 6,
    parameter int AW   = 3
);
    logic            req_a, req_b;
    logic [1:0]      op_a, op_b;
    logic [AW-1:0]   dst_a, dst_b;
    logic [AW-1:0]   src_a, src_b;
    logic [3:0]      wdata_a, wdata_b;
    logic            gnt_a, gnt_b;
    logic            done_a, done_b;
    logic [3:0]      rdata;
    logic [NREG-1:0] reg_inen;
    logic [NREG-1:0] reg_oen;
    logic            reg_clr;
    logic            bus_drv;
    logic [3:0]      bus_wdata;
    logic [3:0]      bus_rdata;
    logic            busy;
`ifdef REG4_BANK_CTRL_ERR_EN
    logic            err_a, err_b;
`endif

    modport slave (
        input  req_a, req_b, op_a, op_b, dst_a, dst_b, src_a, src_b,
               wdata_a, wdata_b, bus_rdata,
        output gnt_a, gnt_b, done_a, done_b, rdata, reg_inen, reg_oen,
               reg_clr, bus_drv, bus_wdata, busy
`ifdef REG4_BANK_CTRL_ERR_EN
             , err_a, err_b
`endif
    );

    modport master (
        output req_a, req_b, op_a, op_b, dst_a, dst_b, src_a, src_b,
               wdata_a, wdata_b, bus_rdata,
        input  gnt_a, gnt_b, done_a, done_b, rdata, reg_inen, reg_oen,
               reg_clr, bus_drv, bus_wdata, busy
`ifdef REG4_BANK_CTRL_ERR_EN
             , err_a, err_b
`endif
    );
endinterface

// File: rtl/reg4_bank_ctrl.sv
// Two-requester round-robin sequencer for a bank of NREG 4-bit registers on a shared bus.
// Define REG4_BANK_CTRL_ERR_EN to get err_a/err_b out-of-range address pulses.
module reg4_bank_ctrl #(
    parameter int NREG = 6,
    parameter int AW   = 3
) (
    input  logic             clk,
    input  logic             clr_n,
    reg4_bank_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    localparam logic [1:0] OP_WR  = 2'b00;
    localparam logic [1:0] OP_RD  = 2'b01;
    localparam logic [1:0] OP_MV  = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;
    localparam logic [AW:0] NREG_W = (AW+1)'(NREG);

    typedef struct packed {
        logic [1:0]    op;
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        logic [3:0]    wdata;
    } cmd_t;

    state_t     state, state_nxt;
    cmd_t       cmd, cmd_nxt;
    logic       owner_b, owner_nxt;
    logic       fav_b, fav_nxt;
    logic       pick_b;
    logic [3:0] rdata_q;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state   <= S_IDLE;
            cmd     <= '0;
            owner_b <= 1'b0;
            fav_b   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cmd     <= cmd_nxt;
            owner_b <= owner_nxt;
            fav_b   <= fav_nxt;
        end
    end

    // fav_b flips to whoever lost, so a pair of continuous requesters alternates.
    always_comb begin
        state_nxt = state;
        cmd_nxt   = cmd;
        owner_nxt = owner_b;
        fav_nxt   = fav_b;
        pick_b    = bus.req_b & (~bus.req_a | fav_b);
        case (state)
            S_IDLE: begin
                if (bus.req_a | bus.req_b) begin
                    state_nxt = S_EXEC;
                    owner_nxt = pick_b;
                    fav_nxt   = ~pick_b;
                    cmd_nxt   = pick_b ? cmd_t'{bus.op_b, bus.src_b, bus.dst_b, bus.wdata_b}
                                       : cmd_t'{bus.op_a, bus.src_a, bus.dst_a, bus.wdata_a};
                end
            end
            S_EXEC:  state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    logic exec, fin;
    logic src_bad, dst_bad, op_bad;
    logic src_en, dst_en;

    assign exec    = (state == S_EXEC);
    assign fin     = (state == S_DONE);
    assign src_bad = {1'b0, cmd.src} >= NREG_W;
    assign dst_bad = {1'b0, cmd.dst} >= NREG_W;

    // An op touching any out-of-range register fires no strobe at all.
    always_comb begin
        op_bad = 1'b0;
        case (cmd.op)
            OP_WR:   op_bad = dst_bad;
            OP_RD:   op_bad = src_bad;
            OP_MV:   op_bad = src_bad | dst_bad;
            default: op_bad = 1'b0;
        endcase
    end

    assign src_en = exec & ~op_bad & ((cmd.op == OP_RD) | (cmd.op == OP_MV));
    assign dst_en = exec & ~op_bad & ((cmd.op == OP_WR) |
                                      ((cmd.op == OP_MV) & (cmd.src != cmd.dst)));

    for (genvar i = 0; i < NREG; i++) begin : g_dec
        assign bus.reg_oen[i]  = src_en & (cmd.src == AW'(i));
        assign bus.reg_inen[i] = dst_en & (cmd.dst == AW'(i));
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)
            rdata_q <= 4'h0;
        else if (exec && cmd.op == OP_RD)
            rdata_q <= bus.bus_rdata;
    end

    assign bus.gnt_a     = exec & ~owner_b;
    assign bus.gnt_b     = exec &  owner_b;
    assign bus.done_a    = fin  & ~owner_b;
    assign bus.done_b    = fin  &  owner_b;
    assign bus.rdata     = rdata_q;
    assign bus.reg_clr   = exec & (cmd.op == OP_CLR);
    assign bus.bus_drv   = exec & ~op_bad & (cmd.op == OP_WR);
    assign bus.bus_wdata = bus.bus_drv ? cmd.wdata : 4'h0;
    assign bus.busy      = (state != S_IDLE);

`ifdef REG4_BANK_CTRL_ERR_EN
    assign bus.err_a = fin & ~owner_b & op_bad;
    assign bus.err_b = fin &  owner_b & op_bad;
`endif
endmodule

// File: tb/tb_reg4_bank_ctrl.sv
// Randomized bench for reg4_bank_ctrl against a cycle-scheduled transaction model,
// with a small register-bank model on the bus and directed literal checks.
module tb_reg4_bank_ctrl;
    localparam int NREG = 6;
    localparam int AW   = 3;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    reg4_bank_ctrl_if #(.NREG(NREG), .AW(AW)) bus ();
    reg4_bank_ctrl #(.NREG(NREG), .AW(AW)) dut (.clk(clk), .clr_n(clr_n), .bus(bus));

    // External bank: loads from the bus on inen, drives the bus on oen.
    logic [3:0] bank [NREG] = '{default: 4'h0};
    always_comb begin
        bus.bus_rdata = 4'h0;
        if (bus.bus_drv) bus.bus_rdata = bus.bus_wdata;
        for (int i = 0; i < NREG; i++)
            if (bus.reg_oen[i]) bus.bus_rdata = bank[i];
    end
    always @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (bus.reg_clr)          bank[i] <= 4'h0;
            else if (bus.reg_inen[i]) bank[i] <= bus.bus_rdata;
        end
    end

    // Expected outputs for one clock period.
    typedef struct packed {
        bit            gnt_a, gnt_b, done_a, done_b, err_a, err_b;
        bit            clr, drv, busy;
        bit [NREG-1:0] inen, oen;
        bit [3:0]      wd;
        bit            is_exec, bad;
        bit [1:0]      op;
        int            src, dst;
        bit [3:0]      wdata;
        bit            rd_vld;
        bit [3:0]      rd_val;
    } exp_t;

    exp_t     expq [int];
    exp_t     cur;
    int       free_at = 0;
    bit       fav_b = 1'b0;
    bit [3:0] cur_rd = 4'h0;
    bit [3:0] mb [NREG] = '{default: 4'h0};
    int       n = 0;
    int       pass_cnt = 0;
    int       total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s cycle %0d: got %0h, expected %0h", name, n, act, req);
    endtask

    function automatic bit oor(input int a);
        return a >= NREG;
    endfunction

    // Decide what the posedge about to happen does, per the op/arbitration rules.
    task automatic decide();
        int p;
        exp_t e, d;
        bit pb;
        int s, t;
        p = n + 1;
        if (!clr_n) begin
            expq.delete();
            free_at = 0;
            fav_b   = 1'b0;
            cur_rd  = 4'h0;
            return;
        end
        if (expq.exists(p - 1) && expq[p-1].is_exec) begin
            e = expq[p-1];
            if (!e.bad) begin
                case (e.op)
                    2'd0: mb[e.dst] = e.wdata;
                    2'd2: mb[e.dst] = mb[e.src];
                    2'd3: for (int i = 0; i < NREG; i++) mb[i] = 4'h0;
                    default: ;
                endcase
            end
            if (e.op == 2'd1) begin
                d = expq[p];
                d.rd_vld = 1'b1;
                d.rd_val = e.bad ? 4'h0 : mb[e.src];
                expq[p] = d;
            end
        end
        if (p >= free_at && (bus.req_a || bus.req_b)) begin
            pb = bus.req_b && (!bus.req_a || fav_b);
            fav_b = !pb;
            e = '0;
            d = '0;
            e.op    = pb ? bus.op_b : bus.op_a;
            s       = int'(pb ? bus.src_b : bus.src_a);
            t       = int'(pb ? bus.dst_b : bus.dst_a);
            e.src   = s;
            e.dst   = t;
            e.wdata = pb ? bus.wdata_b : bus.wdata_a;
            e.bad   = (e.op == 2'd0 && oor(t)) || (e.op == 2'd1 && oor(s)) ||
                      (e.op == 2'd2 && (oor(s) || oor(t)));
            e.is_exec = 1'b1;
            e.busy  = 1'b1;
            e.gnt_a = !pb;
            e.gnt_b = pb;
            if (e.op == 2'd3) e.clr = 1'b1;
            else if (!e.bad) begin
                case (e.op)
                    2'd0: begin e.inen[t] = 1'b1; e.drv = 1'b1; e.wd = e.wdata; end
                    2'd1: e.oen[s] = 1'b1;
                    default: begin e.oen[s] = 1'b1; if (s != t) e.inen[t] = 1'b1; end
                endcase
            end
            d.busy   = 1'b1;
            d.done_a = !pb;
            d.done_b = pb;
            d.err_a  = !pb && e.bad;
            d.err_b  = pb && e.bad;
            expq[p]   = e;
            expq[p+1] = d;
            free_at   = p + 3;
        end
    endtask

    task automatic compare();
        cur = expq.exists(n) ? expq[n] : exp_t'('0);
        if (cur.rd_vld) cur_rd = cur.rd_val;
        chk("gnt_a",     32'(bus.gnt_a),     32'(cur.gnt_a));
        chk("gnt_b",     32'(bus.gnt_b),     32'(cur.gnt_b));
        chk("done_a",    32'(bus.done_a),    32'(cur.done_a));
        chk("done_b",    32'(bus.done_b),    32'(cur.done_b));
        chk("reg_inen",  32'(bus.reg_inen),  32'(cur.inen));
        chk("reg_oen",   32'(bus.reg_oen),   32'(cur.oen));
        chk("reg_clr",   32'(bus.reg_clr),   32'(cur.clr));
        chk("bus_drv",   32'(bus.bus_drv),   32'(cur.drv));
        chk("bus_wdata", 32'(bus.bus_wdata), 32'(cur.wd));
        chk("busy",      32'(bus.busy),      32'(cur.busy));
        chk("rdata",     32'(bus.rdata),     32'(cur_rd));
`ifdef REG4_BANK_CTRL_ERR_EN
        chk("err_a",     32'(bus.err_a),     32'(cur.err_a));
        chk("err_b",     32'(bus.err_b),     32'(cur.err_b));
`endif
        if (expq.exists(n - 1)) expq.delete(n - 1);
    endtask

    task automatic tick();
        decide();
        @(posedge clk);
        n++;
        @(negedge clk);
        compare();
    endtask

    task automatic set_a(input bit r, input bit [1:0] op, input int s, input int d, input bit [3:0] w);
        bus.req_a = r; bus.op_a = op; bus.src_a = AW'(s); bus.dst_a = AW'(d); bus.wdata_a = w;
    endtask

    task automatic set_b(input bit r, input bit [1:0] op, input int s, input int d, input bit [3:0] w);
        bus.req_b = r; bus.op_b = op; bus.src_b = AW'(s); bus.dst_b = AW'(d); bus.wdata_b = w;
    endtask

    task automatic rnd_cmd(input bit b);
        bit [1:0] op;
        int s, d;
        bit [3:0] w;
        op = 2'($urandom_range(0, 3));
        s  = $urandom_range(0, 7);
        d  = $urandom_range(0, 7);
        w  = 4'($urandom_range(0, 15));
        if (b) set_b(1'b1, op, s, d, w);
        else   set_a(1'b1, op, s, d, w);
    endtask

    initial begin
        set_a(1'b0, 2'd0, 0, 0, 4'h0);
        set_b(1'b0, 2'd0, 0, 0, 4'h0);

        // Reset state
        tick();
        tick();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_rdata", 32'(bus.rdata), 32'd0);
        clr_n = 1'b1;
        tick();

        // A write dst=2 data A
        set_a(1'b1, 2'd0, 0, 2, 4'hA);
        tick();
        chk("wr_gnt_a", 32'(bus.gnt_a), 32'd1);
        chk("wr_inen", 32'(bus.reg_inen), 32'b000100);
        chk("wr_model_inen", 32'(cur.inen), 32'b000100);
        chk("wr_drv", 32'(bus.bus_drv), 32'd1);
        chk("wr_wdata", 32'(bus.bus_wdata), 32'hA);
        bus.req_a = 1'b0;
        tick();
        chk("wr_done_a", 32'(bus.done_a), 32'd1);
        tick();

        // B read src=2
        set_b(1'b1, 2'd1, 2, 0, 4'h0);
        tick();
        chk("rd_oen", 32'(bus.reg_oen), 32'b000100);
        bus.req_b = 1'b0;
        tick();
        chk("rd_done_b", 32'(bus.done_b), 32'd1);
        chk("rd_rdata", 32'(bus.rdata), 32'hA);
        chk("rd_model", 32'(cur_rd), 32'hA);
        tick();

        // Both continuous: A move 2->5, B clear; grants alternate A,B,A
        set_a(1'b1, 2'd2, 2, 5, 4'h0);
        set_b(1'b1, 2'd3, 0, 0, 4'h0);
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk("rr_gnt_a", 32'(bus.gnt_a), 32'(k == 1 || k == 7));
            chk("rr_gnt_b", 32'(bus.gnt_b), 32'(k == 4));
            if (k == 1) begin
                chk("mv_oen", 32'(bus.reg_oen), 32'b000100);
                chk("mv_inen", 32'(bus.reg_inen), 32'b100000);
            end
            if (k == 4) chk("clr_strobe", 32'(bus.reg_clr), 32'd1);
        end
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
        tick();

        // A move 3->3: source enabled, load suppressed
        set_a(1'b1, 2'd2, 3, 3, 4'h0);
        tick();
        chk("mv33_oen", 32'(bus.reg_oen), 32'b001000);
        chk("mv33_inen", 32'(bus.reg_inen), 32'd0);
        bus.req_a = 1'b0;
        tick();
        chk("mv33_done", 32'(bus.done_a), 32'd1);
        tick();

        // A write dst=7: out of range
        set_a(1'b1, 2'd0, 0, 7, 4'h5);
        tick();
        chk("oor_inen", 32'(bus.reg_inen), 32'd0);
        chk("oor_drv", 32'(bus.bus_drv), 32'd0);
        bus.req_a = 1'b0;
        tick();
        chk("oor_done", 32'(bus.done_a), 32'd1);
`ifdef REG4_BANK_CTRL_ERR_EN
        chk("oor_err", 32'(bus.err_a), 32'd1);
`endif
        tick();

        // Reset during EXEC of a write
        set_a(1'b1, 2'd0, 0, 1, 4'h5);
        tick();
        chk("abort_gnt", 32'(bus.gnt_a), 32'd1);
        clr_n = 1'b0;
        #1;
        chk("abort_gnt0", 32'(bus.gnt_a), 32'd0);
        chk("abort_inen0", 32'(bus.reg_inen), 32'd0);
        chk("abort_drv0", 32'(bus.bus_drv), 32'd0);
        chk("abort_busy0", 32'(bus.busy), 32'd0);
        bus.req_a = 1'b0;
        tick();
        chk("abort_nodone", 32'(bus.done_a), 32'd0);
        tick();
        clr_n = 1'b1;
        tick();
        chk("abort_idle", 32'(bus.busy), 32'd0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (clr_n && $urandom_range(0, 499) == 0) clr_n = 1'b0;
            else if (!clr_n) clr_n = 1'b1;
            if (cur.gnt_a) begin
                if ($urandom_range(0, 1) == 1) rnd_cmd(1'b0);
                else bus.req_a = 1'b0;
            end else if (!bus.req_a && $urandom_range(0, 2) == 0) rnd_cmd(1'b0);
            if (cur.gnt_b) begin
                if ($urandom_range(0, 1) == 1) rnd_cmd(1'b1);
                else bus.req_b = 1'b0;
            end else if (!bus.req_b && $urandom_range(0, 2) == 0) rnd_cmd(1'b1);
            tick();
        end
        clr_n = 1'b1;
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
        repeat (4) tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/reg4_bank_ctrl.md
# reg4_bank_ctrl

Sequencer and arbiter for a bank of `NREG` 4-bit load/output-enable registers sharing one 4-bit data bus. Two requesters issue write, read, move or clear operations through a level request / pulse grant handshake. The block round-robins between them and generates one-hot per-register `inen`/`oen` strobes, bus drive and bank clear. It sits between control logic and the register bank.

## Interface
- `NREG`, 6: number of registers in the bank (2..8).
- `AW`, 3: address width, ≥ clog2(NREG).
- `clk`  in  1  system clock, rising edge.
- `clr_n`  in  1  asynchronous, active-low reset.
- `req_a`, `req_b`  in  1  level request per requester.
- `op_a`, `op_b`  in  2  00 write, 01 read, 10 move, 11 clear bank.
- `dst_a`, `dst_b`  in  AW  destination register (write/move).
- `src_a`, `src_b`  in  AW  source register (read/move).
- `wdata_a`, `wdata_b`  in  4  write data.
- `gnt_a`, `gnt_b`  out  1  one-cycle accept pulse.
- `done_a`, `done_b`  out  1  one-cycle completion pulse.
- `rdata`  out  4  read result, valid with `done_x` for op 01; held until next read.
- `reg_inen`  out  NREG  one-hot load enable to bank.
- `reg_oen`  out  NREG  one-hot output enable to bank.
- `reg_clr`  out  1  bank clear strobe.
- `bus_drv`  out  1  controller drives bus with `bus_wdata`.
- `bus_wdata`  out  4  write data onto bus.
- `bus_rdata`  in  4  bus value as seen from bank outputs.
- `busy`  out  1  high in any state but IDLE.

## Operation
- FSM: IDLE → EXEC → DONE → IDLE; all outputs registered or decoded from state plus latched command.
- IDLE: if any `req` high, pick winner, latch its op/src/dst/wdata, go EXEC; else stay.
- Arbitration: single request wins; both high → the requester not granted last wins; pointer resets to favour A.
- EXEC (one cycle): `gnt_x` high; strobes per latched op:
  - write: `reg_inen[dst]`=1, `bus_drv`=1, `bus_wdata`=wdata.
  - read: `reg_oen[src]`=1; `bus_rdata` captured into `rdata` at end of EXEC.
  - move: `reg_oen[src]`=1 and `reg_inen[dst]`=1 same cycle; `bus_drv`=0. src==dst → `reg_inen` suppressed (no-op, still completes).
  - clear: `reg_clr`=1.
- DONE (one cycle): `done_x` high for the granted requester; all strobes 0.
- `req` sampled only in IDLE. A requester still holding `req` when FSM returns to IDLE is granted a new transaction. Requesters drop `req` in the cycle after `gnt`.
- Address ≥ NREG: one-hot decode yields zero, so no strobe fires; transaction still completes.
- At most one bit of `reg_inen` and one of `reg_oen` high at any time; `bus_drv` and `reg_oen` never both high.

## Timing
- Reset (`clr_n`=0, any time, including mid-transaction): state IDLE. All outputs 0, including `gnt`, `done`, `rdata`, `reg_inen`, `reg_oen`, `reg_clr`, `bus_drv`, `bus_wdata` and `busy`. Round-robin pointer favours A. No `done` is issued for an aborted transaction.
- `req` high in IDLE at edge k → EXEC in cycle k+1 (gnt + strobes) → DONE in cycle k+2 (done, rdata valid) → IDLE in cycle k+3.
- Throughput: one transaction per 3 cycles. Back-to-back same requester: next gnt at cycle k+4.

## Configuration
- `REG4_BANK_CTRL_ERR_EN` defined: adds outputs `err_a`, `err_b` (1 bit). In DONE, `err_x` pulses with `done_x` when any address used by the op is ≥ NREG. Clear never errors.
- Undefined: no `err` ports; out-of-range ops complete silently with no strobes.

## Test plan
- Reset mid-EXEC of a write → all outputs 0 next cycle, no `done`; after release, IDLE with `busy`=0.
- A: write dst=2, wdata=4'hA → `gnt_a` at k+1 with `reg_inen`=000100, `bus_drv`=1, `bus_wdata`=A; `done_a` at k+2.
- B: read src=2, bank drives 4'hA → `reg_oen`=000100 at k+1; `rdata`=4'hA with `done_b` at k+2.
- Both request continuously, A move 2→5, B clear → grants alternate A,B,A… every 3 cycles. Move shows `reg_oen`=000100 and `reg_inen`=100000 together; clear shows `reg_clr`=1.
- A move src=dst=3 → `reg_oen`=001000, `reg_inen`=0, `done_a` pulses.
- A write dst=7 (NREG=6) → no strobes, `done_a` pulses. With `REG4_BANK_CTRL_ERR_EN`, `err_a`=1 with `done_a`.
